sc_mul_ctrl: RTL and testbench

Stochastic-computing multiplier controller for the `mul` datapath. It holds two 16-bit LFSR bitstream generators and runs one multiply job per `start`. For each job it converts two unsigned operands into unipolar bitstreams, ANDs them, and counts the product ones over a programmable window of 2^L cycles. It reports the raw count plus a W-bit scaled estimate with a start/busy/done handshake, and is the sequencer the self-convergence loop uses to issue multiply jobs.

---
 rtl/sc_mul_ctrl.sv | 146 ++++++++++++++
 tb/tb_sc_mul_ctrl.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sc_mul_ctrl.sv
// sc_mul_ctrl: stochastic-computing multiplier sequencer.
// Two 16-bit LFSRs turn the captured operands into unipolar bitstreams. The
// AND of those streams is counted over a window of 2^L cycles, and the count
// is scaled back to a W-bit product estimate with a start/busy/done handshake.
module sc_mul_ctrl #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         abort,
  input  logic [W-1:0] op_a,
  input  logic [W-1:0] op_b,
  input  logic [4:0]   len_log2,
  output logic         busy,
  output logic         done,
  output logic [15:0]  count,
  output logic [W-1:0] prod_est,
  output logic         sa_bit,
  output logic         sb_bit,
  output logic         sp_bit
);

  localparam logic [15:0] SEED_A = 16'h269F;
  localparam logic [15:0] SEED_B = 16'hF89A;
  localparam logic [4:0]  L_MIN  = 5'(W);
  localparam logic [4:0]  L_MAX  = 5'd15;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t       state;
  logic [15:0]  lfsr_a;
  logic [15:0]  lfsr_b;
  logic [W-1:0] op_a_q;
  logic [W-1:0] op_b_q;
  logic [4:0]   len_q;
  logic [15:0]  acc;
  logic [14:0]  cyc;

  logic [4:0]   len_clamped;
  logic [14:0]  last_cyc;
  logic         is_last;
  logic [15:0]  acc_final;
  logic [4:0]   shift_amt;
  logic [15:0]  scaled;
  logic [W-1:0] est_sat;

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[4] ^ s[2] ^ s[1]};
  endfunction

  // Stream bits, window bookkeeping and the scaled estimate of the final count
  always_comb begin
    len_clamped = len_log2;
    if (len_log2 < L_MIN) begin
      len_clamped = L_MIN;
    end else if (len_log2 > L_MAX) begin
      len_clamped = L_MAX;
    end

    sa_bit = (state == RUN) && (lfsr_a[W-1:0] < op_a_q);
    sb_bit = (state == RUN) && (lfsr_b[W-1:0] < op_b_q);
    sp_bit = sa_bit & sb_bit;

    last_cyc  = ~(15'h7FFF << len_q);
    is_last   = (cyc == last_cyc);
    acc_final = acc + {15'd0, sp_bit};

    shift_amt = len_q - L_MIN;
    scaled    = acc_final >> shift_amt;
    est_sat   = scaled[W-1:0];
    if (scaled[15:W] != '0) begin
      est_sat = '1;
    end
  end

  // Job sequencer: capture and reseed on start, accumulate in RUN, publish results on completion
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      lfsr_a   <= SEED_A;
      lfsr_b   <= SEED_B;
      op_a_q   <= '0;
      op_b_q   <= '0;
      len_q    <= L_MIN;
      acc      <= '0;
      cyc      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      count    <= '0;
      prod_est <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            state  <= RUN;
            op_a_q <= op_a;
            op_b_q <= op_b;
            len_q  <= len_clamped;
            lfsr_a <= SEED_A;
            lfsr_b <= SEED_B;
            acc    <= '0;
            cyc    <= '0;
            busy   <= 1'b1;
          end else begin
            busy <= 1'b0;
          end
        end
        RUN: begin
          if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
          end else begin
            acc    <= acc_final;
            lfsr_a <= lfsr_step(lfsr_a);
            lfsr_b <= lfsr_step(lfsr_b);
            cyc    <= cyc + 15'd1;
            if (is_last) begin
              state    <= DONE;
              done     <= 1'b1;
              count    <= acc_final;
              prod_est <= est_sat;
            end
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sc_mul_ctrl.sv
// Testbench for sc_mul_ctrl: directed job sequence with a result scoreboard
// fed by a bit-accurate model of the two LFSR bitstreams.
module tb_sc_mul_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic         abort;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic [4:0]   len_log2;
  logic         busy;
  logic         done;
  logic [15:0]  count;
  logic [W-1:0] prod_est;
  logic         sa_bit;
  logic         sb_bit;
  logic         sp_bit;

  typedef struct {
    logic [15:0]  cnt;
    logic [W-1:0] est;
  } exp_t;

  exp_t        sb_q[$];
  int          vectors     = 0;
  int          miscompares = 0;
  int          done_pulses = 0;
  bit          sa_seen     = 0;
  logic [15:0] ref_count;
  logic [W-1:0] ref_est;
  logic [15:0] fresh_count;
  int          pulses_before;

  sc_mul_ctrl #(.W(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .abort    (abort),
    .op_a     (op_a),
    .op_b     (op_b),
    .len_log2 (len_log2),
    .busy     (busy),
    .done     (done),
    .count    (count),
    .prod_est (prod_est),
    .sa_bit   (sa_bit),
    .sb_bit   (sb_bit),
    .sp_bit   (sp_bit)
  );

  // Free-running clock
  always #5 clk = ~clk;

  // Tally of done pulses, used to prove that aborted jobs never signal completion
  always @(negedge clk) begin
    if (done === 1'b1) done_pulses++;
  end

  // Hard stop in case the sequence stalls
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic int clampLen(input int len);
    if (len < W) return W;
    if (len > 15) return 15;
    return len;
  endfunction

  function automatic logic [15:0] modelCount(input logic [W-1:0] a, input logic [W-1:0] b, input int l);
    logic [15:0] la;
    logic [15:0] lb;
    logic [15:0] c;
    la = 16'h269F;
    lb = 16'hF89A;
    c  = 16'd0;
    for (int i = 0; i < (1 << l); i++) begin
      if ((la[W-1:0] < a) && (lb[W-1:0] < b)) c = c + 16'd1;
      la = {la[14:0], la[15] ^ la[4] ^ la[2] ^ la[1]};
      lb = {lb[14:0], lb[15] ^ lb[4] ^ lb[2] ^ lb[1]};
    end
    return c;
  endfunction

  function automatic logic [W-1:0] modelEst(input logic [15:0] c, input int l);
    logic [15:0] s;
    s = c >> (l - W);
    if ((s >> W) != 16'd0) return '1;
    return s[W-1:0];
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Drive a job request at the current negedge and advance to the negedge after acceptance
  task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b, input int len,
                               input bit hold, input bit push);
    exp_t e;
    op_a     = a;
    op_b     = b;
    len_log2 = 5'(len);
    start    = 1'b1;
    if (push) begin
      e.cnt = modelCount(a, b, clampLen(len));
      e.est = modelEst(e.cnt, clampLen(len));
      sb_q.push_back(e);
    end
    @(negedge clk);
    if (!hold) start = 1'b0;
  endtask

  // Wait a bounded number of cycles for done, then score latency and results
  task automatic waitDone(input string tag, input int remaining);
    int   n;
    bit   seen;
    exp_t e;
    n    = 0;
    seen = 0;
    while (!seen && n < remaining + 20) begin
      @(negedge clk);
      n++;
      if (sa_bit === 1'b1) sa_seen = 1;
      if (done === 1'b1) seen = 1;
    end
    checkOutput({tag, "_latency"}, n, remaining);
    if (seen) begin
      checkOutput({tag, "_sb_pending"}, 32'(sb_q.size() != 0), 1);
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        checkOutput({tag, "_count"}, count, e.cnt);
        checkOutput({tag, "_est"}, prod_est, e.est);
      end
    end
  endtask

  // One cycle after done: the pulse is gone and the block is idle
  task automatic checkIdleAfter(input string tag);
    @(negedge clk);
    checkOutput({tag, "_done_width"}, done, 1'b0);
    checkOutput({tag, "_busy_idle"}, busy, 1'b0);
    checkOutput({tag, "_sp_idle"}, sp_bit, 1'b0);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_busy"}, busy, 1'b0);
    checkOutput({tag, "_done"}, done, 1'b0);
    checkOutput({tag, "_count"}, count, 16'd0);
    checkOutput({tag, "_est"}, prod_est, '0);
    checkOutput({tag, "_streams"}, {sa_bit, sb_bit, sp_bit}, 3'b000);
  endtask

  // Directed sequence
  initial begin
    rst_n    = 1'b0;
    start    = 1'b1;
    abort    = 1'b0;
    op_a     = 8'd255;
    op_b     = 8'd255;
    len_log2 = 5'd8;

    // Reset held with start high: nothing starts
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("reset_busy", busy, 1'b0);
    end
    checkAllZero("reset");

    // Release: the start still pending is accepted on the first edge
    rst_n = 1'b1;
    applyStimulus(8'd100, 8'd50, 8, 0, 1);
    checkOutput("release_busy", busy, 1'b1);
    waitDone("release_job", 256);
    checkIdleAfter("release_job");

    // Zero operand: stream A is never high
    sa_seen = 0;
    applyStimulus(8'd0, 8'd200, 8, 0, 1);
    waitDone("zero_op", 256);
    checkOutput("zero_op_sa_never", sa_seen, 1'b0);
    checkOutput("zero_op_count", count, 16'd0);
    checkIdleAfter("zero_op");

    // Window clamp: len 3 behaves as L=8
    applyStimulus(8'd64, 8'd192, 3, 0, 1);
    waitDone("clamp", 256);
    checkIdleAfter("clamp");

    // Determinism: two identical jobs agree with each other and the model
    sa_seen = 0;
    applyStimulus(8'd128, 8'd128, 8, 0, 1);
    waitDone("det1", 256);
    checkOutput("det1_sa_seen", sa_seen, 1'b1);
    fresh_count = count;
    checkIdleAfter("det1");
    applyStimulus(8'd128, 8'd128, 8, 0, 1);
    waitDone("det2", 256);
    checkOutput("det_repeat", count, fresh_count);
    checkIdleAfter("det2");

    // Abort at RUN cycle 10: no done, results unchanged
    ref_count     = count;
    ref_est       = prod_est;
    applyStimulus(8'd200, 8'd30, 8, 0, 0);
    pulses_before = done_pulses;
    repeat (9) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checkOutput("abort10_busy", busy, 1'b0);
    checkOutput("abort10_done", done, 1'b0);
    repeat (300) @(negedge clk);
    checkOutput("abort10_no_pulse", done_pulses, pulses_before);
    checkOutput("abort10_count_hold", count, ref_count);
    checkOutput("abort10_est_hold", prod_est, ref_est);

    // Start with abort high in IDLE is accepted; abort on the final RUN cycle wins
    abort = 1'b1;
    applyStimulus(8'd250, 8'd240, 8, 0, 0);
    abort = 1'b0;
    checkOutput("start_abort_idle_busy", busy, 1'b1);
    pulses_before = done_pulses;
    repeat (255) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checkOutput("abort_last_busy", busy, 1'b0);
    checkOutput("abort_last_done", done, 1'b0);
    repeat (5) @(negedge clk);
    checkOutput("abort_last_no_pulse", done_pulses, pulses_before);
    checkOutput("abort_last_count_hold", count, ref_count);

    // Start pulse and operand changes mid-job do not disturb the running job
    applyStimulus(8'd180, 8'd90, 8, 0, 1);
    repeat (4) @(negedge clk);
    start    = 1'b1;
    op_a     = 8'd0;
    op_b     = 8'd0;
    len_log2 = 5'd15;
    @(negedge clk);
    start = 1'b0;
    waitDone("ignored_start", 251);
    checkIdleAfter("ignored_start");

    // Back-to-back jobs with start held: done every 2^L+2 cycles
    applyStimulus(8'd77, 8'd160, 8, 1, 1);
    begin
      exp_t e;
      e.cnt = modelCount(8'd77, 8'd160, 8);
      e.est = modelEst(e.cnt, 8);
      sb_q.push_back(e);
    end
    waitDone("b2b_first", 256);
    waitDone("b2b_second", 258);
    start = 1'b0;
    checkIdleAfter("b2b");

    // Reset for one cycle at RUN cycle 50, then an identical job reproduces the fresh count
    applyStimulus(8'd128, 8'd128, 8, 0, 0);
    repeat (49) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checkAllZero("midreset");
    applyStimulus(8'd128, 8'd128, 8, 0, 1);
    waitDone("after_reset", 256);
    checkOutput("after_reset_fresh", count, fresh_count);
    checkIdleAfter("after_reset");

    // Longest window with near-unity operands, length request above the maximum
    applyStimulus(8'd255, 8'd255, 20, 0, 1);
    waitDone("full_scale", 32768);
    checkOutput("full_scale_est_range", 32'((prod_est >= 8'd250) && (prod_est <= 8'd255)), 1);
    checkIdleAfter("full_scale");

    checkOutput("sb_drained", sb_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
